// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, direction encoding, request bundle
// and sensor one-hot helpers.
package elevator_pkg;

    localparam int N_FLOORS = 4;
    localparam int FLOOR_W  = 2;
    localparam int CNT_W    = 8;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef logic [N_FLOORS-1:0] fvec_t;

    typedef struct packed {
        fvec_t up;
        fvec_t dn;
        fvec_t car;
    } req_t;

    function automatic logic is_onehot(input fvec_t s);
        return $onehot(s);
    endfunction

    function automatic logic [FLOOR_W-1:0] onehot_idx(input fvec_t s);
        logic [FLOOR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_FLOORS; i++)
            if (s[i]) idx = FLOOR_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/call_request_latch_if.sv
// Button/sensor/controller inputs and latched-request outputs of call_request_latch.
interface call_request_latch_if;
    import elevator_pkg::*;

    logic S1, S2, S3, S4;
    logic U1, U2, U3, U4;
    logic D1, D2, D3, D4;
    logic F1, F2, F3, F4;
    logic up, down, stop, open_door;

    logic [N_FLOORS-1:0] req_up;
    logic [N_FLOORS-1:0] req_dn;
    logic [N_FLOORS-1:0] req_car;
    logic [FLOOR_W-1:0]  cur_floor;
    logic                floor_valid;
    logic                last_dir;
    logic                door_busy;
    logic                pending_any;

    modport slave (
        input  S1, S2, S3, S4, U1, U2, U3, U4, D1, D2, D3, D4,
        input  F1, F2, F3, F4, up, down, stop, open_door,
        output req_up, req_dn, req_car, cur_floor, floor_valid,
        output last_dir, door_busy, pending_any
    );

    modport master (
        output S1, S2, S3, S4, U1, U2, U3, U4, D1, D2, D3, D4,
        output F1, F2, F3, F4, up, down, stop, open_door,
        input  req_up, req_dn, req_car, cur_floor, floor_valid,
        input  last_dir, door_busy, pending_any
    );

endinterface

// File: rtl/floor_decode.sv
// Floor sensor decode: combinational one-hot hit/index plus the registered
// last-valid floor.
module floor_decode
    import elevator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  fvec_t              sens,
    output logic               hit,
    output logic [FLOOR_W-1:0] idx,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               floor_valid
);

    assign hit = is_onehot(sens);
    assign idx = onehot_idx(sens);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_floor   <= '0;
            floor_valid <= 1'b0;
        end else begin
            floor_valid <= hit;
            if (hit) cur_floor <= idx;
        end
    end

endmodule

// File: rtl/call_request_latch.sv
// Latches hall/car calls until served and tracks direction and door dwell
// for the downstream 4-floor controller.
module call_request_latch
    import elevator_pkg::*;
#(
    parameter int DWELL = 8
) (
    input logic           clk,
    input logic           reset,
    call_request_latch_if.slave bus
);

    fvec_t              sens;
    logic               hit;
    logic [FLOOR_W-1:0] idx;
    logic [FLOOR_W-1:0] cur_floor;
    logic               floor_valid;

    req_t               req_q, req_n, btn, clr, sup_q, sup_act;
    fvec_t              any_req;
    logic [CNT_W-1:0]   cnt;
    logic               busy, serve, above, below;
    logic               dir_q, open_prev, pending_q;

    assign sens = {bus.S4, bus.S3, bus.S2, bus.S1};

    floor_decode u_dec (
        .clk         (clk),
        .rst         (reset),
        .sens        (sens),
        .hit         (hit),
        .idx         (idx),
        .cur_floor   (cur_floor),
        .floor_valid (floor_valid)
    );

    assign btn.up  = {1'b0, bus.U3, bus.U2, bus.U1};
    assign btn.dn  = {bus.D4, bus.D3, bus.D2, 1'b0};
    assign btn.car = {bus.F4, bus.F3, bus.F2, bus.F1};

    assign busy    = (cnt != '0);
    assign serve   = bus.stop && bus.open_door && hit && !busy;
    assign any_req = req_q.up | req_q.dn | req_q.car;

    always_comb begin
        clr   = '0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i > int'(idx) && any_req[i]) above = 1'b1;
            if (i < int'(idx) && any_req[i]) below = 1'b1;
        end
        if (serve) begin
            clr.car[idx] = 1'b1;
            if (dir_q == DIR_UP) begin
                clr.up[idx] = 1'b1;
                clr.dn[idx] = !above;
            end else begin
                clr.dn[idx] = 1'b1;
                clr.up[idx] = !below;
            end
        end
    end

    // Buttons for bits cleared by the last serve stay masked while the door dwells.
    assign sup_act = busy ? sup_q : '0;
    assign req_n   = req_t'((req_q | (btn & ~sup_act)) & ~clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= '0;
            sup_q     <= '0;
            pending_q <= 1'b0;
            cnt       <= '0;
            dir_q     <= DIR_UP;
            open_prev <= 1'b0;
        end else begin
            req_q     <= req_n;
            pending_q <= |req_n;
            open_prev <= bus.open_door;
            if (serve) begin
                cnt   <= CNT_W'(DWELL);
                sup_q <= clr;
            end else if (open_prev && !bus.open_door) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt - 1'b1;
            end
            if (bus.up && !bus.down)      dir_q <= DIR_UP;
            else if (bus.down && !bus.up) dir_q <= DIR_DN;
        end
    end

    assign bus.req_up      = req_q.up;
    assign bus.req_dn      = req_q.dn;
    assign bus.req_car     = req_q.car;
    assign bus.cur_floor   = cur_floor;
    assign bus.floor_valid = floor_valid;
    assign bus.last_dir    = dir_q;
    assign bus.door_busy   = busy;
    assign bus.pending_any = pending_q;

endmodule

// File: tb/tb_call_request_latch.sv
// Directed and randomized bench for call_request_latch with a behavioural call model.
module tb_call_request_latch;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    call_request_latch_if bus();

    call_request_latch #(.DWELL(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit mu[4], md[4], mc[4];
    bit mvalid, mdir, mprev, su, sd, sc;
    int mfloor, mcnt, sfl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] v(input bit a[4]);
        return {a[3], a[2], a[1], a[0]};
    endfunction

    task automatic set_idle();
        {bus.S1, bus.S2, bus.S3, bus.S4} = '0;
        {bus.U1, bus.U2, bus.U3, bus.U4} = '0;
        {bus.D1, bus.D2, bus.D3, bus.D4} = '0;
        {bus.F1, bus.F2, bus.F3, bus.F4} = '0;
        {bus.up, bus.down, bus.stop, bus.open_door} = '0;
    endtask

    task automatic at_floor(input int f);
        bus.S1 = (f == 0); bus.S2 = (f == 1); bus.S3 = (f == 2); bus.S4 = (f == 3);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin mu[i] = 0; md[i] = 0; mc[i] = 0; end
        mvalid = 0; mdir = 1; mprev = 0; mfloor = 0; mcnt = 0;
        sfl = 0; su = 0; sd = 0; sc = 0;
    endtask

    task automatic model_step();
        bit s[4], bu[4], bd[4], bc[4], cu[4], cd[4], cc[4];
        bit serve, above, below, blk;
        int ones, k;
        s  = '{bus.S1, bus.S2, bus.S3, bus.S4};
        bu = '{bus.U1, bus.U2, bus.U3, 1'b0};
        bd = '{1'b0, bus.D2, bus.D3, bus.D4};
        bc = '{bus.F1, bus.F2, bus.F3, bus.F4};
        ones = 0; k = 0; above = 0; below = 0;
        for (int i = 0; i < 4; i++) begin
            cu[i] = 0; cd[i] = 0; cc[i] = 0;
            if (s[i]) begin ones++; k = i; end
        end
        serve = bus.stop && bus.open_door && ones == 1 && mcnt == 0;
        if (serve) begin
            for (int j = 0; j < 4; j++)
                if (mu[j] || md[j] || mc[j]) begin
                    if (j > k) above = 1;
                    if (j < k) below = 1;
                end
            cc[k] = 1;
            if (mdir) begin cu[k] = 1; cd[k] = !above; end
            else      begin cd[k] = 1; cu[k] = !below; end
        end
        for (int i = 0; i < 4; i++) begin
            blk = (mcnt != 0) && (i == sfl);
            mu[i] = (mu[i] | (bu[i] & !(blk && su))) & !cu[i];
            md[i] = (md[i] | (bd[i] & !(blk && sd))) & !cd[i];
            mc[i] = (mc[i] | (bc[i] & !(blk && sc))) & !cc[i];
        end
        if (serve) begin
            mcnt = DW; sfl = k; su = cu[k]; sd = cd[k]; sc = cc[k];
        end else if (mprev && !bus.open_door) mcnt = 0;
        else if (mcnt > 0) mcnt--;
        mprev = bus.open_door;
        if (bus.up && !bus.down) mdir = 1;
        else if (bus.down && !bus.up) mdir = 0;
        mvalid = (ones == 1);
        if (ones == 1) mfloor = k;
    endtask

    task automatic check_all();
        chk("req_up", bus.req_up, v(mu));
        chk("req_dn", bus.req_dn, v(md));
        chk("req_car", bus.req_car, v(mc));
        chk("cur_floor", bus.cur_floor, mfloor);
        chk("floor_valid", bus.floor_valid, mvalid);
        chk("last_dir", bus.last_dir, mdir);
        chk("door_busy", bus.door_busy, mcnt != 0);
        chk("pending_any", bus.pending_any, (v(mu) | v(md) | v(mc)) != 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int busy_cycles, pos, r;
        set_idle();
        do_reset();

        // Car call latches with one cycle latency and holds.
        bus.F3 = 1; tick(); bus.F3 = 0;
        chk("f3_latched", bus.req_car, 4'b0100);
        chk("f3_pending", bus.pending_any, 1);
        tick(); tick();
        chk("f3_held", bus.req_car, 4'b0100);

        // Serve going up at floor 2 with a request above.
        do_reset();
        at_floor(1);
        bus.U2 = 1; bus.D2 = 1; bus.F4 = 1; tick();
        bus.U2 = 0; bus.D2 = 0; bus.F4 = 0;
        bus.stop = 1; bus.open_door = 1; tick();
        chk("serve_up_cleared", bus.req_up, 4'b0000);
        chk("serve_dn_kept", bus.req_dn, 4'b0010);
        chk("serve_car", bus.req_car, 4'b1000);
        busy_cycles = bus.door_busy ? 1 : 0;
        bus.stop = 0;
        bus.F2 = 1; bus.U2 = 1; bus.F4 = 1; tick();
        if (bus.door_busy) busy_cycles++;
        bus.F2 = 0; bus.U2 = 0; bus.F4 = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.door_busy) busy_cycles++;
        end
        chk("dwell_len", busy_cycles, DW);
        chk("suppress_up", bus.req_up, 4'b0000);
        chk("suppress_car", bus.req_car, 4'b1000);
        bus.open_door = 0; tick();

        // Serve going down at floor 3 with nothing below.
        do_reset();
        at_floor(2);
        bus.down = 1; tick(); bus.down = 0;
        bus.U3 = 1; tick(); bus.U3 = 0;
        bus.stop = 1; bus.open_door = 1; tick();
        chk("dn_serve_up", bus.req_up, 4'b0000);
        chk("dn_serve_pending", bus.pending_any, 0);
        bus.stop = 0; bus.open_door = 0; tick();

        // Invalid sensors: no floor update, no clears.
        bus.F1 = 1; tick(); bus.F1 = 0;
        bus.S1 = 1; bus.S2 = 0; bus.S3 = 1; bus.S4 = 0;
        bus.stop = 1; bus.open_door = 1; tick();
        chk("inv_valid", bus.floor_valid, 0);
        chk("inv_floor", bus.cur_floor, 2);
        chk("inv_car", bus.req_car, 4'b0001);
        bus.stop = 0; bus.open_door = 0; tick();

        // Async reset mid-dwell with five requests pending.
        do_reset();
        at_floor(0);
        bus.U2 = 1; bus.D3 = 1; bus.D4 = 1; bus.F2 = 1; bus.F4 = 1;
        bus.U4 = 1; bus.D1 = 1; tick();
        bus.U2 = 0; bus.D3 = 0; bus.D4 = 0; bus.F2 = 0; bus.F4 = 0;
        bus.U4 = 0; bus.D1 = 0;
        chk("five_up", bus.req_up, 4'b0010);
        chk("five_dn", bus.req_dn, 4'b1100);
        bus.stop = 1; bus.open_door = 1; tick();
        bus.stop = 0; tick(); tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_pending", bus.pending_any, 0);
        chk("async_busy", bus.door_busy, 0);
        chk("async_dir", bus.last_dir, 1);
        check_all();
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
        bus.U4 = 1; bus.D1 = 1; tick();
        chk("ignored_pins", bus.pending_any, 0);
        bus.U4 = 0; bus.D1 = 0;

        // Randomized traffic.
        pos = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) pos = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r == 0) at_floor(5);
            else if (r == 1) begin at_floor(pos); bus.S4 = 1; bus.S1 = 1; end
            else at_floor(pos);
            {bus.U1, bus.U2, bus.U3, bus.U4} = 4'($urandom() & $urandom() & $urandom());
            {bus.D1, bus.D2, bus.D3, bus.D4} = 4'($urandom() & $urandom() & $urandom());
            {bus.F1, bus.F2, bus.F3, bus.F4} = 4'($urandom() & $urandom() & $urandom());
            r = $urandom_range(0, 3);
            bus.up = (r == 1 || r == 3);
            bus.down = (r == 2 || r == 3);
            bus.stop = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) bus.open_door = ~bus.open_door;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
